mem_bus_bridge: RTL and testbench

- Sits in the MEM stage, directly downstream of the EX/MEM pipeline register, and replaces the direct data_mem hookup.
- Converts the stage's single-cycle load/store requests into a valid/ready bus transaction toward data memory or an external slave.
- Provides a one-entry posted write buffer with store-to-load forwarding.
- Raises STALL to freeze the pipeline while a load or a blocked store is outstanding.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/wr_buffer.sv | 38 +++
 rtl/mem_bus_bridge.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_bridge.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MEM-stage bus bridge.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DRAIN,
    RD_WAIT_DRAIN,
    RD_REQ,
    RD_DONE
  } state_t;

  // Load result presented when a read is abandoned on timeout.
  localparam logic [31:0] ABORT_RDATA = 32'h0;

  function automatic int tmo_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wr_buffer.sv
// One-entry posted write buffer: holds {valid, addr, data} and compares a
// lookup address against the held entry for store-to-load forwarding.
module wr_buffer #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  data,
  output logic              hit
);

  logic              valid;
  logic [ADDR_W-1:0] addr;

  // A new store landing on the drain-complete edge wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= wr_addr;
      data  <= wr_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (addr == rd_addr);

endmodule

// File: rtl/mem_bus_bridge.sv
// MEM-stage load/store to valid/ready bus bridge with a posted write buffer,
// store-to-load forwarding, pipeline stall generation and a bus timeout.
//
// state         | meaning
// IDLE          | no transfer outstanding, write buffer empty
// WR_DRAIN      | buffered store being written on the bus
// RD_WAIT_DRAIN | load missed while draining; waits for the write to finish
// RD_REQ        | read on the bus, pipeline stalled
// RD_DONE       | read data presented for one cycle, pipeline advances
module mem_bus_bridge #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEMREAD_IN,
  input  logic              MEMWRITE_IN,
  input  logic [ADDR_W-1:0] ADDRESS_IN,
  input  logic [WIDTH-1:0]  WRDATA_IN,
  output logic [WIDTH-1:0]  RDDATA_OUT,
  output logic              STALL,
  output logic              BUS_VALID,
  output logic              BUS_WE,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [WIDTH-1:0]  BUS_WDATA,
  input  logic              BUS_READY,
  input  logic [WIDTH-1:0]  BUS_RDATA,
  output logic              BUS_ERR
);
  import mem_bus_pkg::*;

  localparam int CNT_W = tmo_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              bus_valid_q, valid_d;
  logic              bus_we_q, we_d;
  logic [ADDR_W-1:0] bus_addr_q, addr_d;
  logic [WIDTH-1:0]  bus_wdata_q, wdata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]  tmo_q;
  logic              err_q;

  logic              is_load, is_store;
  logic              buf_hit, buf_clear;
  logic [WIDTH-1:0]  buf_data;
  logic              handshake, abort, drain_end;
  logic              stall_raw, issue_wr, issue_rd;

  assign is_store  = MEMWRITE_IN;
  assign is_load   = MEMREAD_IN && !MEMWRITE_IN;
  assign handshake = bus_valid_q && BUS_READY;
  assign abort     = bus_valid_q && !BUS_READY && (tmo_q == TMO_LAST);
  assign drain_end = handshake || abort;

  wr_buffer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_wr_buffer (
    .clk     (clk),
    .rst     (rst),
    .load    (issue_wr),
    .clear   (buf_clear),
    .wr_addr (ADDRESS_IN),
    .wr_data (WRDATA_IN),
    .rd_addr (ADDRESS_IN),
    .data    (buf_data),
    .hit     (buf_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= valid_d;
      bus_we_q    <= we_d;
      bus_addr_q  <= addr_d;
      bus_wdata_q <= wdata_d;
      rdata_q     <= rdata_d;
      if (handshake || abort) tmo_q <= '0;
      else if (bus_valid_q)   tmo_q <= tmo_q + CNT_W'(1);
      if (abort) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = bus_valid_q;
    we_d      = bus_we_q;
    addr_d    = bus_addr_q;
    wdata_d   = bus_wdata_q;
    rdata_d   = rdata_q;
    buf_clear = 1'b0;
    stall_raw = 1'b0;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_store) begin
          issue_wr = 1'b1;
          state_d  = WR_DRAIN;
        end else if (is_load) begin
          stall_raw = 1'b1;
          issue_rd  = 1'b1;
          state_d   = RD_REQ;
        end
      end
      WR_DRAIN: begin
        buf_clear = drain_end;
        if (is_store) begin
          stall_raw = !drain_end;
          issue_wr  = drain_end;
        end else if (is_load && !buf_hit) begin
          stall_raw = 1'b1;
          issue_rd  = drain_end;
          state_d   = drain_end ? RD_REQ : RD_WAIT_DRAIN;
        end else if (drain_end) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      RD_WAIT_DRAIN: begin
        stall_raw = 1'b1;
        buf_clear = drain_end;
        issue_rd  = drain_end;
        if (drain_end) state_d = RD_REQ;
      end
      RD_REQ: begin
        stall_raw = 1'b1;
        if (handshake || abort) begin
          valid_d = 1'b0;
          rdata_d = handshake ? BUS_RDATA : WIDTH'(ABORT_RDATA);
          state_d = RD_DONE;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Address/data/direction only move when a new transfer is launched.
    if (issue_wr || issue_rd) begin
      valid_d = 1'b1;
      we_d    = issue_wr;
      addr_d  = ADDRESS_IN;
      wdata_d = issue_wr ? WRDATA_IN : bus_wdata_q;
    end
  end

  assign BUS_VALID  = bus_valid_q;
  assign BUS_WE     = bus_we_q;
  assign BUS_ADDR   = bus_addr_q;
  assign BUS_WDATA  = bus_wdata_q;
  assign BUS_ERR    = err_q;
  assign STALL      = rst && stall_raw;
  assign RDDATA_OUT = (is_load && buf_hit) ? buf_data : rdata_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: directed scenarios plus random
// load/store traffic checked against a program-order memory model.
module tb_mem_bus_bridge;
  localparam int WIDTH   = 32;
  localparam int ADDR_W  = 11;
  localparam int TIMEOUT = 8;

  logic              clk, rst;
  logic              MEMREAD_IN, MEMWRITE_IN;
  logic [ADDR_W-1:0] ADDRESS_IN;
  logic [WIDTH-1:0]  WRDATA_IN;
  logic [WIDTH-1:0]  RDDATA_OUT;
  logic              STALL, BUS_VALID, BUS_WE, BUS_ERR;
  logic [ADDR_W-1:0] BUS_ADDR;
  logic [WIDTH-1:0]  BUS_WDATA;
  logic              BUS_READY;
  logic [WIDTH-1:0]  BUS_RDATA;

  int checks;
  int failures;
  int cfg_delay;   // -1: random 0..3 wait cycles, otherwise fixed wait count

  logic [WIDTH-1:0] slv_mem [0:2047];
  logic [WIDTH-1:0] ref_mem [0:2047];
  logic [ADDR_W+WIDTH-1:0] wlog [$];
  logic [ADDR_W+WIDTH-1:0] exp_wr [$];

  mem_bus_bridge #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .MEMREAD_IN(MEMREAD_IN), .MEMWRITE_IN(MEMWRITE_IN),
    .ADDRESS_IN(ADDRESS_IN), .WRDATA_IN(WRDATA_IN), .RDDATA_OUT(RDDATA_OUT),
    .STALL(STALL), .BUS_VALID(BUS_VALID), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_READY(BUS_READY), .BUS_RDATA(BUS_RDATA),
    .BUS_ERR(BUS_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: commits at the negedge before a handshake edge, drives READY after posedge.
  initial begin : slave
    bit busy;
    int wcnt, dly;
    busy = 0; wcnt = 0; dly = 0;
    BUS_READY = 1'b0; BUS_RDATA = '0;
    forever begin
      @(negedge clk);
      if (rst && BUS_VALID && BUS_READY) begin
        if (BUS_WE) begin
          slv_mem[BUS_ADDR] = BUS_WDATA;
          wlog.push_back({BUS_ADDR, BUS_WDATA});
        end
        busy = 0;
      end
      @(posedge clk); #1;
      if (BUS_VALID !== 1'b1) begin
        busy = 0;
        BUS_READY = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1;
          wcnt = 0;
          dly  = (cfg_delay < 0) ? int'($urandom_range(0, 3)) : cfg_delay;
        end
        if (wcnt >= dly) begin
          BUS_READY = 1'b1;
          BUS_RDATA = BUS_WE ? $urandom : slv_mem[BUS_ADDR];
        end else begin
          BUS_READY = 1'b0;
          wcnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [WIDTH-1:0] d);
    MEMREAD_IN = rd; MEMWRITE_IN = wr; ADDRESS_IN = a; WRDATA_IN = d;
  endtask

  // From posedge+1: counts stalled cycles, returns at the negedge with STALL low.
  task automatic count_stall(output int n);
    n = 0;
    @(negedge clk);
    while (STALL === 1'b1 && n < 40) begin
      n++;
      tick();
      @(negedge clk);
    end
  endtask

  task automatic wait_bus_idle();
    int n = 0;
    @(negedge clk);
    while (BUS_VALID === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [WIDTH-1:0] d);
    int n = 0;
    drive(rd, wr, a, d);
    @(negedge clk);
    while (STALL === 1'b1 && n < 50) begin
      n++;
      tick();
      @(negedge clk);
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL issue_stall addr=%h stall still high after %0d cycles", a, n);
    end
    if (wr) begin
      ref_mem[a] = d;
      exp_wr.push_back({a, d});
    end else if (rd) begin
      checks++;
      if (RDDATA_OUT !== ref_mem[a]) begin
        failures++;
        $display("FAIL rand_load addr=%h got=%h exp=%h", a, RDDATA_OUT, ref_mem[a]);
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cfg_delay = 0;
    drive(1, 0, 11'h005, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", STALL); end
    checks++; if (BUS_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", BUS_VALID); end
    checks++; if ({BUS_WE, BUS_ADDR, BUS_WDATA} !== '0) begin
      failures++; $display("FAIL rst_bus we=%b addr=%h wdata=%h exp=0", BUS_WE, BUS_ADDR, BUS_WDATA);
    end
    checks++; if (RDDATA_OUT !== '0) begin failures++; $display("FAIL rst_rddata got=%h exp=0", RDDATA_OUT); end
    checks++; if (BUS_ERR !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", BUS_ERR); end
    drive(0, 0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_posted_store();
    int n;
    cfg_delay = 0;
    drive(0, 1, 11'h010, 32'hCAFEF00D);
    ref_mem[11'h010] = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL post_stall got=%b exp=0", STALL); end
    tick();
    drive(0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if ({BUS_VALID, BUS_WE, BUS_ADDR, BUS_WDATA} !== {1'b1, 1'b1, 11'h010, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL post_bus valid=%b we=%b addr=%h wdata=%h exp=1 1 010 cafef00d",
               BUS_VALID, BUS_WE, BUS_ADDR, BUS_WDATA);
    end
    tick();
    @(negedge clk);
    checks++; if (BUS_VALID !== 1'b0) begin failures++; $display("FAIL post_drained got=%b exp=0", BUS_VALID); end
    checks++; if (slv_mem[11'h010] !== 32'hCAFEF00D) begin
      failures++; $display("FAIL post_mem got=%h exp=cafef00d", slv_mem[11'h010]);
    end
    tick();
    drive(1, 0, 11'h010, '0);
    count_stall(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL post_empty_stall got=%0d exp=2", n); end
    checks++; if (RDDATA_OUT !== 32'hCAFEF00D) begin
      failures++; $display("FAIL post_readback got=%h exp=cafef00d", RDDATA_OUT);
    end
    tick();
    drive(0, 0, '0, '0);
  endtask

  task automatic test_forward();
    cfg_delay = 3;
    drive(0, 1, 11'h020, 32'h11111111);
    ref_mem[11'h020] = 32'h11111111;
    @(negedge clk);
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL fwd_store_stall got=%b exp=0", STALL); end
    tick();
    drive(1, 0, 11'h020, '0);
    @(negedge clk);
    checks++; if (RDDATA_OUT !== 32'h11111111) begin
      failures++; $display("FAIL fwd_data got=%h exp=11111111", RDDATA_OUT);
    end
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL fwd_stall got=%b exp=0", STALL); end
    checks++; if ({BUS_WE, BUS_ADDR, BUS_READY} !== {1'b1, 11'h020, 1'b0}) begin
      failures++; $display("FAIL fwd_bus we=%b addr=%h ready=%b exp=1 020 0", BUS_WE, BUS_ADDR, BUS_READY);
    end
    tick();
    drive(0, 0, '0, '0);
    wait_bus_idle();
    checks++; if (BUS_VALID !== 1'b0) begin failures++; $display("FAIL fwd_drain got=%b exp=0", BUS_VALID); end
    tick();
  endtask

  task automatic test_load_wait();
    int n;
    cfg_delay = 3;
    slv_mem[11'h030] = 32'h12345678;
    ref_mem[11'h030] = 32'h12345678;
    drive(1, 0, 11'h030, '0);
    count_stall(n);
    checks++; if (n !== 5) begin failures++; $display("FAIL ld_stall_cycles got=%0d exp=5", n); end
    checks++; if (RDDATA_OUT !== 32'h12345678) begin
      failures++; $display("FAIL ld_data got=%h exp=12345678", RDDATA_OUT);
    end
    tick();
    drive(0, 0, '0, '0);
    @(negedge clk);
    checks++; if ({RDDATA_OUT, STALL, BUS_VALID} !== {32'h12345678, 1'b0, 1'b0}) begin
      failures++; $display("FAIL ld_hold data=%h stall=%b valid=%b exp=12345678 0 0", RDDATA_OUT, STALL, BUS_VALID);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [WIDTH-1:0] da, db;
    da = $urandom; db = $urandom;
    cfg_delay = 2;
    wlog.delete();
    drive(0, 1, 11'h040, da);
    ref_mem[11'h040] = da;
    @(negedge clk);
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL b2b_first_stall got=%b exp=0", STALL); end
    tick();
    drive(0, 1, 11'h044, db);
    @(negedge clk);
    while (STALL === 1'b1 && n < 20) begin
      n++;
      checks++;
      if ({BUS_VALID, BUS_WE, BUS_ADDR, BUS_WDATA} !== {1'b1, 1'b1, 11'h040, da}) begin
        failures++; $display("FAIL b2b_hold addr=%h wdata=%h exp=040 %h", BUS_ADDR, BUS_WDATA, da);
      end
      tick();
      @(negedge clk);
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=2", n); end
    ref_mem[11'h044] = db;
    tick();
    drive(0, 0, '0, '0);
    wait_bus_idle();
    checks++;
    if (wlog.size() != 2) begin
      failures++; $display("FAIL b2b_count got=%0d exp=2", wlog.size());
    end else if (wlog[0] !== {11'h040, da} || wlog[1] !== {11'h044, db}) begin
      failures++; $display("FAIL b2b_order got=%h,%h exp=%h,%h", wlog[0], wlog[1], {11'h040, da}, {11'h044, db});
    end
    tick();
  endtask

  task automatic test_timeout();
    int n = 0, vcnt = 0;
    cfg_delay = 1000;
    drive(1, 0, 11'h050, '0);
    @(negedge clk);
    while (STALL === 1'b1 && n < 40) begin
      n++;
      if (BUS_VALID === 1'b1) vcnt++;
      tick();
      @(negedge clk);
    end
    checks++; if (vcnt !== TIMEOUT) begin failures++; $display("FAIL tmo_wait got=%0d exp=%0d", vcnt, TIMEOUT); end
    checks++; if ({STALL, BUS_VALID, BUS_ERR} !== 3'b001) begin
      failures++; $display("FAIL tmo_flags stall=%b valid=%b err=%b exp=0 0 1", STALL, BUS_VALID, BUS_ERR);
    end
    checks++; if (RDDATA_OUT !== '0) begin failures++; $display("FAIL tmo_data got=%h exp=0", RDDATA_OUT); end
    tick();
    drive(0, 0, '0, '0);
    cfg_delay = 0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (BUS_ERR !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", BUS_ERR); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    cfg_delay = 1000;
    drive(1, 0, 11'h060, '0);
    tick(); tick();
    @(negedge clk);
    checks++; if (BUS_VALID !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b exp=1", BUS_VALID); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({STALL, BUS_VALID, BUS_WE, BUS_ADDR, BUS_WDATA, RDDATA_OUT, BUS_ERR} !== '0) begin
      failures++;
      $display("FAIL rmid_async stall=%b valid=%b we=%b addr=%h wdata=%h rd=%h err=%b exp=all 0",
               STALL, BUS_VALID, BUS_WE, BUS_ADDR, BUS_WDATA, RDDATA_OUT, BUS_ERR);
    end
    drive(0, 0, '0, '0);
    cfg_delay = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if ({STALL, BUS_VALID} !== 2'b00) begin
      failures++; $display("FAIL rmid_idle stall=%b valid=%b exp=0 0", STALL, BUS_VALID);
    end
    tick();
    drive(1, 0, 11'h060, '0);
    count_stall(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL rmid_miss_stall got=%0d exp=2", n); end
    checks++; if (RDDATA_OUT !== ref_mem[11'h060]) begin
      failures++; $display("FAIL rmid_data got=%h exp=%h", RDDATA_OUT, ref_mem[11'h060]);
    end
    tick();
    drive(0, 0, '0, '0);
  endtask

  task automatic test_random();
    int bad;
    logic [ADDR_W-1:0] a;
    cfg_delay = -1;
    wlog.delete();
    exp_wr.delete();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      a = 11'h100 + ADDR_W'($urandom_range(0, 7));
      if (r < 4)      issue(1, 0, a, '0);
      else if (r < 7) issue(0, 1, a, $urandom);
      else if (r < 8) issue(1, 1, a, $urandom);
      else            issue(0, 0, a, '0);
    end
    drive(0, 0, '0, '0);
    wait_bus_idle();
    tick();
    checks++;
    if (wlog.size() != exp_wr.size()) begin
      failures++; $display("FAIL rand_wr_count got=%0d exp=%0d", wlog.size(), exp_wr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < wlog.size(); i++) if (wlog[i] !== exp_wr[i]) bad++;
      if (bad != 0) begin failures++; $display("FAIL rand_wr_order mismatched=%0d exp=0", bad); end
    end
    bad = 0;
    for (int i = 'h100; i < 'h108; i++) if (slv_mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_mem mismatched=%0d exp=0", bad); end
    checks++; if (BUS_ERR !== 1'b0) begin failures++; $display("FAIL rand_err got=%b exp=0", BUS_ERR); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cfg_delay = 0;
    rst = 1'b0;
    MEMREAD_IN = 1'b0; MEMWRITE_IN = 1'b0; ADDRESS_IN = '0; WRDATA_IN = '0;
    for (int i = 0; i < 2048; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    test_reset();
    test_posted_store();
    test_forward();
    test_load_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
